bram_access_arbiter: RTL

- Shares the single byte-addressed, four-bank B-RAM (behind bram_addresser) between the instruction-fetch port and the data (memory-stage) port.
- Issues at most one access per cycle and tracks in-flight loads across the one-cycle synchronous B-RAM read latency.
- Returns registered read data to the owning port, with a valid pulse.
- Sits between the IF/MEM pipeline stages and bram_addresser.

---
 rtl/bram_access_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/bram_access_arbiter.sv
// Shares the single four-bank B-RAM between the instruction-fetch and data ports.
// One grant per cycle; a two-stage tag pipeline steers read data back to its owner.
module bram_access_arbiter #(
  parameter int unsigned ADDR_W       = 18,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        CLOCK_50,
  input  logic        reset,

  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  output logic        if_rvalid,

  input  logic        mem_req,
  input  logic [4:0]  mem_access_code,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_rvalid,
  output logic        mem_fault,

  output logic [4:0]  bram_access_code,
  output logic [31:0] bram_address,
  output logic [31:0] bram_data_to_store,
  input  logic [31:0] bram_read_data
);

  localparam int unsigned CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [4:0]  FETCH_CODE = 5'b11110;

  typedef enum logic [1:0] {
    TAG_NONE  = 2'd0,
    TAG_FETCH = 2'd1,
    TAG_DATA  = 2'd2
  } tag_t;

  logic [CNT_W-1:0] r_starve_cnt;
  tag_t             r_tag;
  logic             r_tag_oor;
  logic             r_mem_fault;
  logic [31:0]      r_if_rdata;
  logic             r_if_rvalid;
  logic [31:0]      r_mem_rdata;
  logic             r_mem_rvalid;

  logic             w_if_oor;
  logic             w_mem_oor;
  logic             w_starved;
  logic             w_if_grant;
  logic             w_mem_grant;
  tag_t             w_issue_tag;
  logic             w_issue_oor;

  // Any bit above the implemented byte-address width marks the access out of range
  generate
    if (ADDR_W < 32) begin : g_oor
      assign w_if_oor  = |if_addr[31:ADDR_W];
      assign w_mem_oor = |mem_addr[31:ADDR_W];
    end else begin : g_no_oor
      assign w_if_oor  = 1'b0;
      assign w_mem_oor = 1'b0;
    end
  endgenerate

  // Data has priority unless fetch has lost STARVE_LIMIT times in a row
  assign w_starved   = (r_starve_cnt == CNT_W'(STARVE_LIMIT));
  assign w_if_grant  = !reset && if_req && (!mem_req || w_starved);
  assign w_mem_grant = !reset && mem_req && !w_if_grant;

  assign if_ready  = w_if_grant;
  assign mem_ready = w_mem_grant;

  always_comb begin
    bram_access_code   = 5'b00000;
    bram_address       = 32'h0;
    bram_data_to_store = 32'h0;
    w_issue_tag        = TAG_NONE;
    w_issue_oor        = 1'b0;
    if (w_if_grant) begin
      bram_access_code = FETCH_CODE;
      bram_address     = if_addr;
      w_issue_tag      = TAG_FETCH;
      w_issue_oor      = w_if_oor;
    end else if (w_mem_grant) begin
      // Out-of-range data accesses degrade to a harmless no-enable load
      bram_access_code   = w_mem_oor ? 5'b00000 : mem_access_code;
      bram_address       = mem_addr;
      bram_data_to_store = mem_wdata;
      w_issue_tag        = mem_access_code[0] ? TAG_NONE : TAG_DATA;
      w_issue_oor        = w_mem_oor;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (if_req && !w_if_grant) begin
      r_starve_cnt <= w_starved ? r_starve_cnt : r_starve_cnt + CNT_W'(1);
    end else begin
      r_starve_cnt <= '0;
    end
  end

  // Stage 1: tag of the load whose data arrives from the B-RAM next cycle
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_tag       <= TAG_NONE;
      r_tag_oor   <= 1'b0;
      r_mem_fault <= 1'b0;
    end else begin
      r_tag       <= w_issue_tag;
      r_tag_oor   <= w_issue_oor;
      r_mem_fault <= w_mem_grant && w_mem_oor;
    end
  end

  // Stage 2: capture read data into the owning port and pulse its valid
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_if_rdata   <= 32'h0;
      r_if_rvalid  <= 1'b0;
      r_mem_rdata  <= 32'h0;
      r_mem_rvalid <= 1'b0;
    end else begin
      r_if_rvalid  <= (r_tag == TAG_FETCH);
      r_mem_rvalid <= (r_tag == TAG_DATA);
      if (r_tag == TAG_FETCH) begin
        r_if_rdata <= r_tag_oor ? 32'h0 : bram_read_data;
      end
      if (r_tag == TAG_DATA) begin
        r_mem_rdata <= r_tag_oor ? 32'h0 : bram_read_data;
      end
    end
  end

  assign if_rdata   = r_if_rdata;
  assign if_rvalid  = r_if_rvalid;
  assign mem_rdata  = r_mem_rdata;
  assign mem_rvalid = r_mem_rvalid;
  assign mem_fault  = r_mem_fault;

endmodule
